rr_arbiter_4: RTL

- Four-requester round-robin arbiter.
- Shares a single resource (e.g. a bus or a decoded select line) among four clients.
- Issues a one-hot grant and a binary grant index. The one-hot grant is produced by the existing 2-to-4 binary decoder, with its enable driven by grant-valid.
- A programmable hold limit prevents any requester from monopolising the resource.

---
 rtl/rr_arbiter_4_pkg.sv | 35 +++
 rtl/rr_arbiter_4_dec.sv | 19 +
 rtl/rr_arbiter_4.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
// Provides:
//   - sizing constants (requester count, index and counter widths)
//   - the arbiter state encoding
//   - rr_pick, the rotating-priority search used for every grant decision
package rr_arbiter_4_pkg;

  localparam int unsigned NumReq = 4;
  localparam int unsigned IdxW   = 2;
  localparam int unsigned CntW   = 8;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

  // Scans req starting at ptr and wrapping mod 4; the first set bit wins.
  // The result is {found, index}, and the index is 0 when nothing is found.
  function automatic logic [IdxW:0] rr_pick(logic [NumReq-1:0] req, logic [IdxW-1:0] ptr);
    logic            found;
    logic [IdxW-1:0] idx;
    logic [IdxW-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand = ptr + IdxW'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/rr_arbiter_4_dec.sv
// 2-to-4 binary decoder with enable.
// Ports:
//   A  - binary select
//   en - enable; when it is low, D is all-zero
//   D  - one-hot output
module dec_2_to_4 (
  input  logic [1:0] A,
  input  logic       en,
  output logic [3:0] D
);

  always_comb begin
    D = 4'b0000;
    if (en) begin
      D = 4'b0001 << A;
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a programmable hold limit.
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-high reset
//   req     - request vector; bit i means requester i wants the resource
//   gnt     - registered one-hot grant; all-zero when there is no grant
//   gnt_idx - registered binary index of the grantee; 0 when there is no grant
//   gnt_vld - high while a grant is active
//   timeout - one-cycle pulse on the cycle in which a forced release takes effect
// Parameter:
//   HOLD_MAX - maximum number of consecutive cycles a grant may be held; 0 means no limit
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NumReq-1:0] req,
  output logic [NumReq-1:0] gnt,
  output logic [IdxW-1:0]   gnt_idx,
  output logic              gnt_vld,
  output logic              timeout
);

  localparam bit HoldEn = (HOLD_MAX != 0);
  // Last legal value of cnt before a forced release. It is only used when HoldEn is set.
  localparam logic [CntW-1:0] HoldLast = HoldEn ? CntW'(HOLD_MAX - 1) : '0;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   gnt_idx_next;
  logic              gnt_vld_next;
  logic [NumReq-1:0] gnt_next;
  logic              timeout_d;

  logic [IdxW:0]     pick_full;
  logic [IdxW:0]     pick_masked;

  // The current holder is masked so that a release or timeout hands the grant to someone else.
  assign pick_full   = rr_pick(req, ptr_q);
  assign pick_masked = rr_pick(req & ~(4'b0001 << gnt_idx), ptr_q);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    gnt_idx_next = gnt_idx;
    gnt_vld_next = gnt_vld;
    timeout_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_full[IdxW]) begin
          state_d      = StGrant;
          gnt_vld_next = 1'b1;
          gnt_idx_next = pick_full[IdxW-1:0];
          ptr_d        = pick_full[IdxW-1:0] + 2'd1;
          cnt_d        = '0;
        end
      end
      StGrant: begin
        if (!req[gnt_idx]) begin
          if (pick_masked[IdxW]) begin
            gnt_idx_next = pick_masked[IdxW-1:0];
            ptr_d        = pick_masked[IdxW-1:0] + 2'd1;
            cnt_d        = '0;
          end else begin
            state_d      = StIdle;
            gnt_vld_next = 1'b0;
            gnt_idx_next = '0;
            cnt_d        = '0;
          end
        end else if (!HoldEn || (cnt_q < HoldLast)) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          if (pick_masked[IdxW]) begin
            gnt_idx_next = pick_masked[IdxW-1:0];
            ptr_d        = pick_masked[IdxW-1:0] + 2'd1;
          end else begin
            // The holder is the only requester, so it is re-granted.
            ptr_d = gnt_idx + 2'd1;
          end
        end
      end
      default: begin
        state_d      = StIdle;
        gnt_vld_next = 1'b0;
        gnt_idx_next = '0;
      end
    endcase
  end

  dec_2_to_4 u_dec (
    .A  (gnt_idx_next),
    .en (gnt_vld_next),
    .D  (gnt_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt     <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt     <= gnt_next;
      gnt_idx <= gnt_idx_next;
      gnt_vld <= gnt_vld_next;
      timeout <= timeout_d;
    end
  end

endmodule
